// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding imem reads
// and buffers returned words in a small FIFO feeding the IF/ID boundary.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcAddr,
  output logic [31:0] instr,
  output logic        if_dWrite
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          discard;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          resp;
  logic          issue;
  logic [CW:0]   occupancy;

  always_comb begin
    pop       = !stall && (count != '0) && !jump_en;
    // A slot is reserved for every granted request, so the FIFO cannot overflow.
    occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};
    imem_req  = rst && !jump_en && (!outstanding || imem_rvalid) && (occupancy < DEPTH_C);
    issue     = imem_req && imem_gnt;
    resp      = imem_rvalid && outstanding && !jump_en;
    push      = resp && !discard;
    imem_addr = fetch_pc;
    pcAddr    = (count != '0) ? fifo_pc[rd_ptr]    : '0;
    instr     = (count != '0) ? fifo_instr[rd_ptr] : '0;
    if_dWrite = (count == '0) | jump_en;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (jump_en) begin
      fetch_pc    <= jump_addr & ~32'h3;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // A response landing in the jump cycle is consumed and dropped here;
      // one still in flight is dropped later via discard.
      outstanding <= outstanding && !imem_rvalid;
      discard     <= outstanding && !imem_rvalid;
    end else begin
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp)
        discard <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule
